// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg: shared definitions for fifo_rr_scheduler.
//   STATE_BITS        width of the exported FSM state
//   HIGH_DEF/LOW_DEF  default threshold values after reset
//   state_t           FSM state encoding (RESET..ERROR)
package fifo_sched_pkg;
  localparam int STATE_BITS = 3;
  localparam int HIGH_DEF   = 6;
  localparam int LOW_DEF    = 2;

  typedef enum logic [STATE_BITS-1:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority picker.
//   req    in  NUM_Q  request vector (one bit per queue)
//   last   in  IDX_W  index of the previous grant
//   grant  out NUM_Q  one-hot grant, first requester after 'last'
//   valid  out 1      at least one request is present
module rr_arbiter #(
  parameter int NUM_Q = 4,
  parameter int IDX_W = 2
) (
  input  logic [NUM_Q-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [NUM_Q-1:0] grant,
  output logic             valid
);
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    valid = 1'b0;
    // Offsets 1..NUM_Q visit every queue once; offset NUM_Q is 'last' itself,
    // so a lone requester keeps winning every cycle.
    for (int k = 1; k <= NUM_Q; k++) begin
      idx = (int'(last) + k) % NUM_Q;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: drains NUM_Q upstream FIFOs round-robin into one
// downstream FIFO and distributes the high/low thresholds.
// Optional feature macro: SCHED_WORD_COUNT_EN (adds word_count port/counters).
// Ports:
//   clk, reset (async, active-low)
//   init, high_limit_in, low_limit_in  configuration request and thresholds
//   high_limit, low_limit              thresholds driven to all FIFOs
//   q_empty, q_error, q_data, q_read   upstream FIFO bank interface
//   out_almost_full, out_data, out_write downstream FIFO interface
//   state, idle, error_out             status
//   word_count                         per-queue write counts (macro only)
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int DATA_BITS = 10,
  parameter int ADDR_BITS = 3,
  parameter int NUM_Q     = 4,
  parameter int HIGH      = HIGH_DEF,
  parameter int LOW       = LOW_DEF,
  parameter int CNT_BITS  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [ADDR_BITS-1:0]       high_limit_in,
  input  logic [ADDR_BITS-1:0]       low_limit_in,
  output logic [ADDR_BITS-1:0]       high_limit,
  output logic [ADDR_BITS-1:0]       low_limit,
  input  logic [NUM_Q-1:0]           q_empty,
  input  logic [NUM_Q-1:0]           q_error,
  input  logic [NUM_Q*DATA_BITS-1:0] q_data,
  output logic [NUM_Q-1:0]           q_read,
  input  logic                       out_almost_full,
  output logic [DATA_BITS-1:0]       out_data,
  output logic                       out_write,
  output logic [STATE_BITS-1:0]      state,
  output logic                       idle,
  output logic                       error_out
`ifdef SCHED_WORD_COUNT_EN
  ,
  output logic [NUM_Q*CNT_BITS-1:0]  word_count
`endif
);
  localparam int IDX_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;

  state_t           cur_state, nxt_state;
  logic [IDX_W-1:0] last_grant;
  logic [NUM_Q-1:0] grant;
  logic             grant_vld;
  logic [IDX_W-1:0] grant_idx;
  logic             pop_en, pop;
  logic             any_err, any_req, drained;
  logic             vld_p1;
  logic [IDX_W-1:0] src_p0, src_p1, src_p2;

  assign any_err = |q_error;
  assign any_req = |(~q_empty);
  // Nothing popped, nothing waiting on q_data, nothing in the output register.
  assign drained = ~(|q_read) & ~vld_p1 & ~out_write;
  assign pop     = pop_en & grant_vld;
  assign state   = cur_state;
  assign idle    = (cur_state == S_IDLE) & drained;

  rr_arbiter #(.NUM_Q(NUM_Q), .IDX_W(IDX_W)) u_arb (
    .req   (~q_empty),
    .last  (last_grant),
    .grant (grant),
    .valid (grant_vld)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  always_comb begin
    nxt_state = cur_state;
    pop_en    = 1'b0;
    case (cur_state)
      S_RESET: nxt_state = S_INIT;
      S_INIT: begin
        if (any_err)    nxt_state = S_ERROR;
        else if (!init) nxt_state = S_IDLE;
      end
      S_IDLE: begin
        if (any_err)                          nxt_state = S_ERROR;
        else if (init)                        nxt_state = S_INIT;
        else if (any_req && !out_almost_full) nxt_state = S_ACTIVE;
      end
      S_ACTIVE: begin
        // A pending init stops new pops so the pipeline can drain first.
        pop_en = !any_err && !init && !out_almost_full;
        if (any_err)                          nxt_state = S_ERROR;
        else if ((init || !any_req) && drained)
          nxt_state = init ? S_INIT : S_IDLE;
      end
      S_ERROR: nxt_state = S_ERROR;
      default: nxt_state = S_RESET;
    endcase
  end

  // Stage p0: pop strobe registered; the FIFO pops at the end of this cycle.
  // Stage p1: popped word is on q_data; capture it into out_data.
  // Stage p2: out_data/out_write presented downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state  <= S_RESET;
      q_read     <= '0;
      vld_p1     <= 1'b0;
      out_write  <= 1'b0;
      out_data   <= '0;
      error_out  <= 1'b0;
      last_grant <= IDX_W'(NUM_Q - 1);
      high_limit <= ADDR_BITS'(HIGH);
      low_limit  <= ADDR_BITS'(LOW);
    end else begin
      cur_state <= nxt_state;
      q_read    <= pop ? grant : '0;
      if (pop) last_grant <= grant_idx;
      vld_p1    <= |q_read;
      out_write <= vld_p1;
      if (vld_p1) out_data <= q_data[int'(src_p1)*DATA_BITS +: DATA_BITS];
      if (nxt_state == S_ERROR) error_out <= 1'b1;
      if (cur_state == S_INIT && low_limit_in < high_limit_in) begin
        high_limit <= high_limit_in;
        low_limit  <= low_limit_in;
      end
    end
  end

  // Source index travels alongside the valid bits; qualified by them, so no reset.
  always_ff @(posedge clk) begin
    if (pop) src_p0 <= grant_idx;
    src_p1 <= src_p0;
    src_p2 <= src_p1;
  end

`ifdef SCHED_WORD_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_count <= '0;
    end else if (nxt_state == S_INIT && cur_state != S_INIT) begin
      word_count <= '0;
    end else if (out_write) begin
      word_count[int'(src_p2)*CNT_BITS +: CNT_BITS] <=
        word_count[int'(src_p2)*CNT_BITS +: CNT_BITS] + CNT_BITS'(1);
    end
  end
`endif
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
module tb_fifo_rr_scheduler;
  localparam int DB = 10;
  localparam int AB = 3;
  localparam int NQ = 4;
`ifdef SCHED_WORD_COUNT_EN
  localparam int CB = 2;
`else
  localparam int CB = 8;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            init = 1'b0;
  logic [AB-1:0]   high_limit_in = '0, low_limit_in = '0;
  logic [AB-1:0]   high_limit, low_limit;
  logic [NQ-1:0]   q_empty, q_error = '0, q_read;
  logic [NQ*DB-1:0] q_data;
  logic            out_almost_full = 1'b0;
  logic [DB-1:0]   out_data;
  logic            out_write;
  logic [2:0]      state;
  logic            idle, error_out;
`ifdef SCHED_WORD_COUNT_EN
  logic [NQ*CB-1:0] word_count;
`endif

  fifo_rr_scheduler #(.DATA_BITS(DB), .ADDR_BITS(AB), .NUM_Q(NQ),
                      .HIGH(6), .LOW(2), .CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .init(init),
    .high_limit_in(high_limit_in), .low_limit_in(low_limit_in),
    .high_limit(high_limit), .low_limit(low_limit),
    .q_empty(q_empty), .q_error(q_error), .q_data(q_data), .q_read(q_read),
    .out_almost_full(out_almost_full), .out_data(out_data), .out_write(out_write),
    .state(state), .idle(idle), .error_out(error_out)
`ifdef SCHED_WORD_COUNT_EN
    , .word_count(word_count)
`endif
  );

  always #5 clk = ~clk;

  // Upstream FIFO bank model: word appears on q_data the cycle after the pop,
  // q_empty already discounts the pop currently being strobed.
  logic [DB-1:0] mem [NQ][16];
  int            wr [NQ] = '{default: 0};
  int            rd [NQ] = '{default: 0};
  logic [DB-1:0] qd [NQ];
  logic          underflow = 1'b0;

  always_comb begin
    q_empty = '0;
    q_data  = '0;
    for (int i = 0; i < NQ; i++) begin
      q_empty[i] = ((wr[i] - rd[i]) - int'(q_read[i])) <= 0;
      q_data[i*DB +: DB] = qd[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NQ; i++) begin
      if (q_read[i]) begin
        if (wr[i] == rd[i]) underflow <= 1'b1;
        qd[i] <= mem[i][rd[i] % 16];
        rd[i] <= rd[i] + 1;
      end
    end
  end

  int vectors = 0, miscompares = 0;
  logic [DB-1:0] sb[$];
  int cyc = 0, pop_count, wr_count, first_pop, last_pop, first_wr, last_wr;
  logic [NQ-1:0] first_pop_mask, pop_or;
  logic onehot_bad = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int q, input logic [DB-1:0] v, input bit expect_out);
    mem[q][wr[q] % 16] = v;
    wr[q] = wr[q] + 1;
    if (expect_out) sb.push_back(v);
  endtask

  task automatic clr_stats();
    pop_count = 0; wr_count = 0; first_pop = 0; last_pop = 0;
    first_wr = 0; last_wr = 0; pop_or = '0; first_pop_mask = '0;
  endtask

  task automatic tick();
    logic [DB-1:0] exp;
    @(posedge clk);
    #1;
    cyc++;
    if (q_read != '0) begin
      if (pop_count == 0) begin first_pop = cyc; first_pop_mask = q_read; end
      last_pop = cyc;
      pop_count++;
      pop_or |= q_read;
      if ($countones(q_read) != 1) onehot_bad = 1'b1;
    end
    if (out_write) begin
      if (wr_count == 0) first_wr = cyc;
      last_wr = cyc;
      wr_count++;
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      check("out_data", 32'(out_data), 32'(exp));
    end
  endtask

  task automatic run_until_idle(input string tag, input int max);
    bit done = 0;
    for (int i = 0; i < max && !done; i++) begin
      tick();
      if (state == 3'd2 && idle && sb.size() == 0 && pop_count > 0) done = 1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  int p, wb;

  initial begin
    clr_stats();
    // Reset and defaults
    repeat (2) tick();
    check("rst_state", 32'(state), 0);
    check("rst_q_read", 32'(q_read), 0);
    check("rst_out_write", 32'(out_write), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_high", 32'(high_limit), 6);
    check("rst_low", 32'(low_limit), 2);
    check("rst_idle", 32'(idle), 0);
    check("rst_error", 32'(error_out), 0);
    init = 1; high_limit_in = 5; low_limit_in = 1; reset = 1;
    tick(); check("st_init", 32'(state), 1);
    tick(); check("st_init2", 32'(state), 1);
    check("ld_high", 32'(high_limit), 5);
    check("ld_low", 32'(low_limit), 1);
    init = 0;
    tick(); check("st_idle", 32'(state), 2);
    check("idle_flag", 32'(idle), 1);
    // Invalid limits are ignored
    init = 1; high_limit_in = 3; low_limit_in = 5;
    tick(); check("st_reinit", 32'(state), 1);
    tick();
    init = 0;
    tick(); check("st_idle2", 32'(state), 2);
    check("keep_high", 32'(high_limit), 5);
    check("keep_low", 32'(low_limit), 1);

    // Round robin: 2 words in each queue
    clr_stats();
    for (int i = 0; i < NQ; i++) push(i, DB'(10'h10 + i), 0);
    for (int i = 0; i < NQ; i++) push(i, DB'(10'h20 + i), 0);
    for (int i = 0; i < NQ; i++) sb.push_back(DB'(10'h10 + i));
    for (int i = 0; i < NQ; i++) sb.push_back(DB'(10'h20 + i));
    run_until_idle("rr", 60);
    check("rr_latency", 32'(first_wr - first_pop), 2);
    check("rr_back_to_back", 32'(last_wr - first_wr), 7);
    check("rr_writes", 32'(wr_count), 8);
    check("rr_idle", 32'(idle), 1);

    // Single non-empty queue
    clr_stats();
    for (int k = 0; k < 3; k++) push(2, DB'(10'h30 + k), 1);
    run_until_idle("single", 40);
    check("single_pops", 32'(pop_count), 3);
    check("single_consecutive", 32'(last_pop - first_pop), 2);
    check("single_mask", 32'(pop_or), 32'b0100);
    check("single_writes", 32'(wr_count), 3);

    // Back-pressure mid-burst
    clr_stats();
    for (int k = 0; k < 4; k++) begin
      push(0, DB'(10'h40 + k), 1);
      push(1, DB'(10'h50 + k), 1);
    end
    repeat (4) tick();
    out_almost_full = 1;
    p = pop_count; wb = wr_count;
    tick(); check("bp_no_pop", 32'(q_read), 0);
    repeat (4) tick();
    check("bp_pops_frozen", 32'(pop_count), 32'(p));
    check("bp_max_two_writes", 32'((wr_count - wb) <= 2), 1);
    check("bp_state", 32'(state), 3);
    out_almost_full = 0;
    run_until_idle("bp", 60);
    check("bp_total_writes", 32'(wr_count), 8);

    // Error while active: queue 3 served (pointer left at queue 1)
    clr_stats();
    for (int k = 0; k < 4; k++) push(3, DB'(10'h60 + k), k < 2);
    tick(); check("err_active", 32'(state), 3);
    tick(); check("err_pop1", 32'(q_read), 32'b1000);
    tick();
    q_error = 4'b0010;
    tick();
    check("err_state", 32'(state), 4);
    check("err_flag", 32'(error_out), 1);
    check("err_no_pop", 32'(q_read), 0);
    init = 1; q_error = '0;
    p = pop_count;
    repeat (6) tick();
    check("err_pops_frozen", 32'(pop_count), 32'(p));
    check("err_sticky_state", 32'(state), 4);
    check("err_sticky_flag", 32'(error_out), 1);
    check("err_inflight_done", 32'(wr_count), 2);
    check("err_sb_empty", 32'(sb.size()), 0);

    // Asynchronous reset returns outputs immediately
    reset = 0; init = 0; high_limit_in = 6; low_limit_in = 2;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_error", 32'(error_out), 0);
    check("arst_high", 32'(high_limit), 6);
    check("arst_low", 32'(low_limit), 2);
    check("arst_write", 32'(out_write), 0);

    // Grant pointer reset: queue 0 served before leftover queue 3 words
    clr_stats();
    push(0, 10'h070, 0);
    sb.push_back(10'h070); sb.push_back(10'h062); sb.push_back(10'h063);
    tick();
    reset = 1;
    run_until_idle("ptr", 40);
    check("ptr_first_q0", 32'(first_pop_mask), 32'b0001);
    check("ptr_writes", 32'(wr_count), 3);

`ifdef SCHED_WORD_COUNT_EN
    init = 1;
    tick(); check("cnt_state_init", 32'(state), 1);
    check("cnt_clear", 32'(word_count), 0);
    init = 0;
    tick();
    clr_stats();
    for (int k = 0; k < 5; k++) push(0, DB'(10'h80 + k), 1);
    run_until_idle("cnt", 40);
    check("cnt_wrap", 32'(word_count), 32'h01);
    init = 1;
    tick(); check("cnt_init_clear", 32'(word_count), 0);
    init = 0;
    tick();
`endif

    check("no_underflow", 32'(underflow), 0);
    check("onehot_pops", 32'(onehot_bad), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
